// File: rtl/fb_memaccess_pkg.sv
// Shared types for the MEM-stage access unit: FSM encoding, RV32I funct3 width codes
// and the legality/alignment helpers used by the start/fault decode.
package fb_memaccess_pkg;

   typedef enum logic [1:0] {
      MA_IDLE = 2'b00,
      MA_BUSY = 2'b01,
      MA_DONE = 2'b10
   } ma_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // f3[1:0] gives the access size for every legal code: 00 byte, 01 half, 10 word.
   function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic ok;
      case (f3[1:0])
         2'b01:   ok = !addr_lo[0];
         2'b10:   ok = (addr_lo == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/fb_memaccess_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface fb_memaccess_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
   modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/fb_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
// Purely combinational so a future cache can reuse it on its own read path.
module fb_load_align
   import fb_memaccess_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{24{byte_v[7]}}, byte_v};
         F3_H:    data = {{16{half_v[15]}}, half_v};
         F3_BU:   data = {24'h000000, byte_v};
         F3_HU:   data = {16'h0000, half_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/fb_memaccess.sv
// MEM-stage access unit: issues one load/store per instruction over the req/ack bus,
// stalls the pipeline until it completes and holds the extended load result for MEM/WB.
//
// state   | meaning
// MA_IDLE | no access in flight; decode start/fault from the MEM-stage instruction
// MA_BUSY | request held on the bus, waiting for ack
// MA_DONE | access finished, stall released so MEM/WB captures this instruction
module fb_memaccess
   import fb_memaccess_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_mem_read,
   input  logic                  mem_mem_write,
   input  logic [2:0]            mem_funct3,
   input  logic [31:0]           mem_alu_res,
   input  logic [31:0]           mem_store_data,
   fb_memaccess_if.master        dmem,
   output logic [31:0]           mem_memory_data,
   output logic                  mem_stall,
   output logic                  mem_fault
);

   ma_state_e   state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] load_q, load_d;

   logic        access;
   logic        is_store;
   logic        ok;
   logic        in_idle;
   logic        start;
   logic        fault;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] load_ext;

   // A simultaneous read+write is treated as a store.
   assign access   = mem_mem_read | mem_mem_write;
   assign is_store = mem_mem_write;
   assign ok       = f3_legal(mem_funct3, is_store) & addr_aligned(mem_funct3, mem_alu_res[1:0]);
   assign in_idle  = (state_q == MA_IDLE);
   assign start    = in_idle & access & ok;
   assign fault    = in_idle & access & !ok;

   always_comb begin
      st_wdata = mem_store_data;
      st_wstrb = 4'b1111;
      case (mem_funct3[1:0])
         2'b00: begin
            st_wdata = {4{mem_store_data[7:0]}};
            st_wstrb = 4'b0001 << mem_alu_res[1:0];
         end
         2'b01: begin
            st_wdata = {2{mem_store_data[15:0]}};
            st_wstrb = 4'b0011 << {mem_alu_res[1], 1'b0};
         end
         default: begin
            st_wdata = mem_store_data;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   fb_load_align u_load_align (
      .rdata   (dmem.rdata),
      .addr_lo (addr_q[1:0]),
      .funct3  (funct3_q),
      .data    (load_ext)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      load_d   = load_q;
      case (state_q)
         MA_IDLE: begin
            if (start) begin
               state_d  = MA_BUSY;
               addr_d   = mem_alu_res;
               we_d     = is_store;
               funct3_d = mem_funct3;
               wdata_d  = is_store ? st_wdata : 32'h0000_0000;
               wstrb_d  = is_store ? st_wstrb : 4'b0000;
            end
         end
         MA_BUSY: begin
            if (dmem.ack) begin
               state_d = MA_DONE;
               if (!we_q) begin
                  load_d = load_ext;
               end
            end
         end
         MA_DONE: state_d = MA_IDLE;
         default: state_d = MA_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MA_IDLE;
         addr_q   <= 32'h0000_0000;
         wdata_q  <= 32'h0000_0000;
         wstrb_q  <= 4'b0000;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         load_q   <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         load_q   <= load_d;
      end
   end

   // req follows the state flop, so an async reset drops it immediately.
   assign dmem.req        = (state_q == MA_BUSY);
   assign dmem.we         = we_q;
   assign dmem.addr       = {addr_q[31:2], 2'b00};
   assign dmem.wdata      = wdata_q;
   assign dmem.wstrb      = wstrb_q;
   assign mem_memory_data = load_q;
   assign mem_stall       = rst_n & (start | (state_q == MA_BUSY));
   assign mem_fault       = rst_n & fault;

endmodule
